// File: rtl/code_decoder_stretch.sv
// Binary-index to one-hot decoder that holds each decoded line for HOLD_CYCLES clocks.
// Optional one-entry skid buffer for gap-free pulses: define CODE_DECODER_SKID_EN.
module code_decoder_stretch #(
    parameter int unsigned N_OUT       = 4,
    parameter int unsigned CODE_W      = 2,
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic [N_OUT-1:0]  dec_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    localparam logic [CNT_W-1:0]  HoldLoad = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CODE_W:0]   NOutLim  = (CODE_W + 1)'(N_OUT);
    localparam logic [N_OUT-1:0]  OneLsb   = N_OUT'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_OUT-1:0]  dec_q, dec_d;
    logic              busy_q, done_q, done_d, err_q, err_d;
    logic              accept, code_ok;

`ifdef CODE_DECODER_SKID_EN
    logic              skid_full_q, skid_full_d;
    logic [CODE_W-1:0] skid_code_q, skid_code_d;

    assign in_ready = (state_q == StIdle) || !skid_full_q;
`else
    assign in_ready = (state_q == StIdle);
`endif

    assign accept  = in_valid & in_ready;
    assign code_ok = {1'b0, in_code} < NOutLim;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef CODE_DECODER_SKID_EN
        skid_full_d = skid_full_q;
        skid_code_d = skid_code_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (code_ok) begin
                        dec_d   = OneLsb << in_code;
                        cnt_d   = HoldLoad;
                        state_d = StHold;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StHold: begin
`ifdef CODE_DECODER_SKID_EN
                if (accept) begin
                    if (code_ok) begin
                        skid_full_d = 1'b1;
                        skid_code_d = in_code;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    done_d  = 1'b1;
                    dec_d   = '0;
                    state_d = StIdle;
`ifdef CODE_DECODER_SKID_EN
                    // A code arriving on the final cycle bypasses the empty skid directly.
                    if (skid_full_q) begin
                        dec_d       = OneLsb << skid_code_q;
                        cnt_d       = HoldLoad;
                        state_d     = StHold;
                        skid_full_d = 1'b0;
                    end else if (accept && code_ok) begin
                        dec_d       = OneLsb << in_code;
                        cnt_d       = HoldLoad;
                        state_d     = StHold;
                        skid_full_d = 1'b0;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            busy_q  <= |dec_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef CODE_DECODER_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_full_q <= 1'b0;
            skid_code_q <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_code_q <= skid_code_d;
        end
    end
`endif

    assign dec_out = dec_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: doc/code_decoder_stretch.md
Name: code_decoder_stretch

Overview:
- Decoding counterpart to the team's 4-input priority encoder.
- Accepts a binary index with a valid bit, which is the encoder's output format.
- Drives the matching one-hot line for a programmable number of clock cycles.
- Sits between encoder-driven control logic and downstream strobe consumers. It uses a valid/ready handshake so the sender knows when a new code can be taken.

Parameters:
- N_OUT, 4, number of one-hot output lines; legal codes are 0..N_OUT-1.
- CODE_W, 2, width of in_code; must satisfy 2**CODE_W >= N_OUT.
- HOLD_CYCLES, 3, cycles each decoded line stays high; legal range 1..255.
- CNT_W, 8, width of the internal hold counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sender presents a code this cycle.
- in_code  input  CODE_W  binary index to decode.
- in_ready  output  1  block can accept a code this cycle; combinational from state.
- dec_out  output  N_OUT  registered one-hot output; all zeros when idle.
- busy  output  1  high while any dec_out bit is high.
- done  output  1  one-cycle pulse on the cycle dec_out returns to zero.
- err  output  1  one-cycle pulse when an out-of-range code is accepted.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: dec_out=0, busy=0, done=0, err=0, hold counter=0, state=IDLE, skid empty. in_ready=1 while rst is deasserted after reset.
- Reset asserted mid-hold clears dec_out immediately, without waiting for a clock edge. No done pulse is generated.
- Accept condition: accept = in_valid & in_ready. in_code is sampled only on accept.
- IDLE:
  - in_ready=1.
  - On accept with in_code < N_OUT: next cycle dec_out = 1<<in_code, counter = HOLD_CYCLES-1, state goes to HOLD. Latency from accept to dec_out is one cycle.
  - On accept with in_code >= N_OUT: err=1 on the next cycle for one cycle. dec_out stays 0 and state stays IDLE.
- HOLD:
  - in_ready=0 (skid variant: see Optional Feature).
  - Counter decrements each cycle while nonzero.
  - On the cycle counter==0, next cycle: dec_out=0, done=1 for one cycle, state goes to IDLE.
  - Each line is therefore high for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1: dec_out pulses for a single cycle, and IDLE is re-entered immediately after.
- Back-to-back operation (base build): after done, in_ready is 1 again. A code accepted on the done cycle drives dec_out on the following cycle, so at least one all-zero cycle separates consecutive pulses.
- Output invariants:
  - At most one dec_out bit is high at any time.
  - busy = |dec_out, registered alongside dec_out.
- Invalid codes never affect the counter or dec_out. err may coincide with done only in the skid build.

Optional Feature:
- Macro: CODE_DECODER_SKID_EN.
- Defined: a one-entry skid register is added.
  - In HOLD, in_ready=1 while the skid is empty, and an accepted valid code is stored there.
  - On the counter==0 cycle with the skid full, the next cycle loads dec_out with the skid code and reloads the counter with HOLD_CYCLES-1. There is no zero gap. done still pulses for that cycle to mark the completed pulse.
  - An invalid code accepted into the skid raises err on the next cycle and is discarded.
  - The skid is cleared by rst.
- Undefined: no skid register, in_ready=0 throughout HOLD, and the base behaviour applies exactly.

Test Plan:
- Reset check: assert rst mid-cycle with dec_out=0100 -> dec_out=0000, busy=0, in_ready=1 immediately, with no clock edge needed.
- Single decode (HOLD_CYCLES=3): in_valid=1, in_code=2 for one cycle -> dec_out=0100 for exactly 3 cycles, then 0000 with done=1 for one cycle.
- Full sweep: codes 0,1,2,3 sent sequentially, each waiting for in_ready -> dec_out=0001, 0010, 0100, 1000 in order. Each is high for 3 cycles, with one zero cycle between pulses in the base build.
- Out-of-range (N_OUT=3): in_code=3 -> err=1 for one cycle, dec_out stays 000, no done pulse.
- Backpressure: hold in_valid=1 with in_code=1 throughout a HOLD -> in_ready=0 during HOLD and only one accept per pulse (base). With CODE_DECODER_SKID_EN: the second code is accepted during HOLD, and dec_out goes 0010 directly into 0010 with no zero cycle.
- HOLD_CYCLES=1 stress: four back-to-back valid codes -> each line is high for exactly one cycle, done pulses once per code, and err never asserts.
